// File: rtl/ram_rd_arbiter.sv
// Two-channel round-robin arbiter for one synchronous RAM read port.
// Each channel has one outstanding read at most and a one-entry response register.
module ram_rd_arbiter #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  output logic                  req1_ready,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_data,
  input  logic                  rsp1_ready,
  input  logic                  req2_valid,
  input  logic [ADDR_WIDTH-1:0] req2_addr,
  output logic                  req2_ready,
  output logic                  rsp2_valid,
  output logic [DATA_WIDTH-1:0] rsp2_data,
  input  logic                  rsp2_ready,
  output logic                  ram_rd_en,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);

  logic                  r_inflight1;
  logic                  r_inflight2;
  logic                  r_rsp1_valid;
  logic                  r_rsp2_valid;
  logic [DATA_WIDTH-1:0] r_rsp1_data;
  logic [DATA_WIDTH-1:0] r_rsp2_data;
  logic                  r_last_gnt2;
  logic                  w_elig1;
  logic                  w_elig2;
  logic                  w_gnt1;
  logic                  w_gnt2;

  // A channel may issue when its slot is free or is being drained this cycle.
  always_comb begin
    w_elig1 = 1'b0;
    w_elig2 = 1'b0;
    w_gnt1  = 1'b0;
    w_gnt2  = 1'b0;
    if (rst) begin
      w_elig1 = 1'b0;
      w_elig2 = 1'b0;
    end else begin
      w_elig1 = req1_valid & ~r_inflight1 & (~r_rsp1_valid | rsp1_ready);
      w_elig2 = req2_valid & ~r_inflight2 & (~r_rsp2_valid | rsp2_ready);
    end
    if (w_elig1 && w_elig2) begin
      if (r_last_gnt2) begin
        w_gnt1 = 1'b1;
      end else begin
        w_gnt2 = 1'b1;
      end
    end else begin
      w_gnt1 = w_elig1;
      w_gnt2 = w_elig2;
    end
  end

  always_comb begin
    ram_rd_en   = w_gnt1 | w_gnt2;
    ram_rd_addr = {ADDR_WIDTH{1'b0}};
    if (w_gnt1) begin
      ram_rd_addr = req1_addr;
    end else if (w_gnt2) begin
      ram_rd_addr = req2_addr;
    end else begin
      ram_rd_addr = {ADDR_WIDTH{1'b0}};
    end
  end

  assign req1_ready = w_gnt1;
  assign req2_ready = w_gnt2;
  assign rsp1_valid = r_rsp1_valid;
  assign rsp2_valid = r_rsp2_valid;
  assign rsp1_data  = r_rsp1_data;
  assign rsp2_data  = r_rsp2_data;

  // Grant bookkeeping: in-flight flags and round-robin history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight1 <= 1'b0;
      r_inflight2 <= 1'b0;
      r_last_gnt2 <= 1'b1;
    end else begin
      r_inflight1 <= w_gnt1;
      r_inflight2 <= w_gnt2;
      if (w_gnt1) begin
        r_last_gnt2 <= 1'b0;
      end else if (w_gnt2) begin
        r_last_gnt2 <= 1'b1;
      end else begin
        r_last_gnt2 <= r_last_gnt2;
      end
    end
  end

  // Response registers: a capture wins over a simultaneous consume.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp1_valid <= 1'b0;
      r_rsp2_valid <= 1'b0;
      r_rsp1_data  <= {DATA_WIDTH{1'b0}};
      r_rsp2_data  <= {DATA_WIDTH{1'b0}};
    end else begin
      if (r_inflight1) begin
        r_rsp1_valid <= 1'b1;
        r_rsp1_data  <= ram_rd_data;
      end else if (rsp1_ready) begin
        r_rsp1_valid <= 1'b0;
      end else begin
        r_rsp1_valid <= r_rsp1_valid;
      end
      if (r_inflight2) begin
        r_rsp2_valid <= 1'b1;
        r_rsp2_data  <= ram_rd_data;
      end else if (rsp2_ready) begin
        r_rsp2_valid <= 1'b0;
      end else begin
        r_rsp2_valid <= r_rsp2_valid;
      end
    end
  end

endmodule

// File: tb/tb_ram_rd_arbiter.sv
// Directed bench for ram_rd_arbiter with a behavioural synchronous RAM.
module tb_ram_rd_arbiter;

  localparam int AW = 6;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          req1_valid, req2_valid, rsp1_ready, rsp2_ready;
  logic [AW-1:0] req1_addr, req2_addr;
  logic          req1_ready, req2_ready, rsp1_valid, rsp2_valid;
  logic [DW-1:0] rsp1_data, rsp2_data;
  logic          ram_rd_en;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_rd_data;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_rd_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_ready(rsp1_ready),
    .req2_valid(req2_valid), .req2_addr(req2_addr), .req2_ready(req2_ready),
    .rsp2_valid(rsp2_valid), .rsp2_data(rsp2_data), .rsp2_ready(rsp2_ready),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
  );

  // RAM read data appears the cycle after the enable.
  always @(posedge clk) begin
    if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 64'h100 + 64'(i);
    mem[1] = 64'h11; mem[2] = 64'h22; mem[3] = 64'h33; mem[4] = 64'h44; mem[5] = 64'hA5;
    ram_rd_data = 64'h0;
    rst = 1'b1;
    req1_valid = 1'b1; req1_addr = 6'd7;
    req2_valid = 1'b1; req2_addr = 6'd9;
    rsp1_ready = 1'b1; rsp2_ready = 1'b1;

    // Reset: no grants even with requests valid, response state cleared.
    step(); mid();
    chk("rst_req1_ready", 64'(req1_ready), 64'd0);
    chk("rst_req2_ready", 64'(req2_ready), 64'd0);
    chk("rst_ram_en", 64'(ram_rd_en), 64'd0);
    chk("rst_ram_addr", 64'(ram_rd_addr), 64'd0);
    chk("rst_rsp1_valid", 64'(rsp1_valid), 64'd0);
    chk("rst_rsp2_valid", 64'(rsp2_valid), 64'd0);
    chk("rst_rsp1_data", rsp1_data, 64'd0);
    chk("rst_rsp2_data", rsp2_data, 64'd0);

    // Single read of RAM[5] on channel 1, granted in the first cycle out of reset.
    step();
    rst = 1'b0; req2_valid = 1'b0; req1_addr = 6'd5;
    mid();
    chk("single_req1_ready", 64'(req1_ready), 64'd1);
    chk("single_req2_ready", 64'(req2_ready), 64'd0);
    chk("single_ram_en", 64'(ram_rd_en), 64'd1);
    chk("single_ram_addr", 64'(ram_rd_addr), 64'd5);
    step(); req1_valid = 1'b0; mid();
    chk("single_t1_rsp1_valid", 64'(rsp1_valid), 64'd0);
    chk("single_t1_ram_en", 64'(ram_rd_en), 64'd0);
    step(); mid();
    chk("single_t2_rsp1_valid", 64'(rsp1_valid), 64'd1);
    chk("single_t2_rsp1_data", rsp1_data, 64'hA5);
    step(); mid();
    chk("single_t3_rsp1_valid", 64'(rsp1_valid), 64'd0);

    // Tie after a fresh reset alternates ch1, ch2, ch1, ch2.
    rst = 1'b1; step(); rst = 1'b0;
    req1_valid = 1'b1; req1_addr = 6'd1; req2_valid = 1'b1; req2_addr = 6'd2;
    mid();
    chk("tie0_req1_ready", 64'(req1_ready), 64'd1);
    chk("tie0_req2_ready", 64'(req2_ready), 64'd0);
    chk("tie0_addr", 64'(ram_rd_addr), 64'd1);
    step(); mid();
    chk("tie1_req1_ready", 64'(req1_ready), 64'd0);
    chk("tie1_req2_ready", 64'(req2_ready), 64'd1);
    chk("tie1_addr", 64'(ram_rd_addr), 64'd2);
    step(); mid();
    chk("tie2_req1_ready", 64'(req1_ready), 64'd1);
    chk("tie2_req2_ready", 64'(req2_ready), 64'd0);
    chk("tie2_addr", 64'(ram_rd_addr), 64'd1);
    chk("tie2_rsp1_data", rsp1_data, 64'h11);
    step(); mid();
    chk("tie3_req1_ready", 64'(req1_ready), 64'd0);
    chk("tie3_req2_ready", 64'(req2_ready), 64'd1);
    chk("tie3_addr", 64'(ram_rd_addr), 64'd2);
    chk("tie3_rsp2_data", rsp2_data, 64'h22);
    step(); req1_valid = 1'b0; req2_valid = 1'b0;
    step(); step(); mid();
    chk("drain_rsp1_valid", 64'(rsp1_valid), 64'd0);
    chk("drain_rsp2_valid", 64'(rsp2_valid), 64'd0);

    // Backpressure on channel 1.
    step(); rsp1_ready = 1'b0; req1_valid = 1'b1; req1_addr = 6'd3;
    mid();
    chk("bp_a_req1_ready", 64'(req1_ready), 64'd1);
    step(); req1_addr = 6'd4; mid();
    chk("bp_a1_req1_ready", 64'(req1_ready), 64'd0);
    step(); mid();
    chk("bp_a2_rsp1_valid", 64'(rsp1_valid), 64'd1);
    chk("bp_a2_rsp1_data", rsp1_data, 64'h33);
    chk("bp_a2_req1_ready", 64'(req1_ready), 64'd0);
    step(); mid();
    chk("bp_a3_rsp1_data", rsp1_data, 64'h33);
    chk("bp_a3_req1_ready", 64'(req1_ready), 64'd0);
    step(); rsp1_ready = 1'b1; mid();
    chk("bp_a4_req1_ready", 64'(req1_ready), 64'd1);
    chk("bp_a4_addr", 64'(ram_rd_addr), 64'd4);
    step(); req1_valid = 1'b0;
    step(); mid();
    chk("bp_a6_rsp1_valid", 64'(rsp1_valid), 64'd1);
    chk("bp_a6_rsp1_data", rsp1_data, 64'h44);
    step(); step();

    // Channel 2 streaming: one grant every other cycle, data in order.
    req2_valid = 1'b1; req2_addr = 6'd3; mid();
    chk("st0_req2_ready", 64'(req2_ready), 64'd1);
    chk("st0_addr", 64'(ram_rd_addr), 64'd3);
    step(); req2_addr = 6'd4; mid();
    chk("st1_req2_ready", 64'(req2_ready), 64'd0);
    step(); mid();
    chk("st2_req2_ready", 64'(req2_ready), 64'd1);
    chk("st2_rsp2_data", rsp2_data, 64'h33);
    step(); req2_addr = 6'd5; mid();
    chk("st3_req2_ready", 64'(req2_ready), 64'd0);
    step(); mid();
    chk("st4_req2_ready", 64'(req2_ready), 64'd1);
    chk("st4_rsp2_data", rsp2_data, 64'h44);
    step(); req2_valid = 1'b0;
    step(); mid();
    chk("st6_rsp2_valid", 64'(rsp2_valid), 64'd1);
    chk("st6_rsp2_data", rsp2_data, 64'hA5);
    step(); step();

    // Reset mid-flight: grant ch1, reset during T+1, tie afterwards goes to ch1.
    req1_valid = 1'b1; req1_addr = 6'd2; mid();
    chk("rmf_t_req1_ready", 64'(req1_ready), 64'd1);
    step(); req1_valid = 1'b0; rst = 1'b1; mid();
    chk("rmf_t1_rsp1_valid", 64'(rsp1_valid), 64'd0);
    step(); mid();
    chk("rmf_rst_rsp1_valid", 64'(rsp1_valid), 64'd0);
    chk("rmf_rst_ram_en", 64'(ram_rd_en), 64'd0);
    step(); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("rmf_post_rsp1_valid", 64'(rsp1_valid), 64'd0);
      step();
    end
    req1_valid = 1'b1; req1_addr = 6'd1; req2_valid = 1'b1; req2_addr = 6'd2;
    mid();
    chk("rmf_tie_req1_ready", 64'(req1_ready), 64'd1);
    chk("rmf_tie_req2_ready", 64'(req2_ready), 64'd0);
    step(); req1_valid = 1'b0; req2_valid = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
